// File: rtl/conv_pkg.sv
// Shared state encoding, default element sizes and a channel-packing helper
// for the conv stack sequencer.
package conv_pkg;

    localparam int DEF_W = 16;
    localparam int DEF_C = 4;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        START,
        WAIT,
        CACHE,
        OUTPUT,
        ERROR
    } seq_state_t;

    // Channel 0 lands in the least significant bits.
    function automatic logic [DEF_C*DEF_W-1:0] pack_ch(input logic [DEF_C-1:0][DEF_W-1:0] ch);
        logic [DEF_C*DEF_W-1:0] v;
        v = '0;
        for (int c = 0; c < DEF_C; c++) begin
            v[c*DEF_W +: DEF_W] = ch[c];
        end
        return v;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-layer watchdog: up-counter with synchronous clear and enable; tc flags the
// TIMEOUT-th enabled cycle since the last clear.
module seq_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc = (cnt_q == TC_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_stack_sequencer.sv
// Control sequencer for a stack of dilated causal conv layers: accept sample,
// run each layer in turn, hold the final output. Optional CONV_SEQ_PERF_EN adds perf_cycles.
module conv_stack_sequencer
    import conv_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int C          = DEF_C,
    parameter int NUM_LAYERS = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_data,
    output logic [W-1:0]          sample_q,
    output logic                  lsb_shift,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [NUM_LAYERS-2:0] cache_shift,
    input  logic [C*W-1:0]        layer_out,
    output logic [C*W-1:0]        out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  error,
    output logic [2:0]            err_layer,
`ifdef CONV_SEQ_PERF_EN
    output logic [15:0]           perf_cycles,
`endif
    input  logic                  err_clear
);

    localparam logic [2:0]            LAST  = 3'(NUM_LAYERS - 1);
    localparam logic [NUM_LAYERS-1:0] ONE_L = NUM_LAYERS'(1);
    localparam logic [NUM_LAYERS-2:0] ONE_C = (NUM_LAYERS - 1)'(1);

    seq_state_t state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [W-1:0] sample_d;
    logic [C*W-1:0] out_data_q, out_data_d;
    logic [2:0] err_layer_q, err_layer_d;
    logic in_ready_q, in_ready_d, lsb_shift_q, lsb_shift_d;
    logic out_valid_q, out_valid_d, busy_q, busy_d, error_q, error_d;
    logic [NUM_LAYERS-1:0] layer_start_q, layer_start_d;
    logic [NUM_LAYERS-2:0] cache_shift_q, cache_shift_d;
    logic wd_clr, wd_en, wd_tc, cur_done;

    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk (clk),
        .rst (rst),
        .clr (wd_clr),
        .en  (wd_en),
        .tc  (wd_tc)
    );

    // Masking avoids a dynamic bit-select wider than the done vector needs.
    assign cur_done = |(layer_done & (ONE_L << idx_q));

    // Strobes and status are computed from the next state so every output is a flop.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        sample_d      = sample_q;
        out_data_d    = out_data_q;
        err_layer_d   = err_layer_q;
        in_ready_d    = 1'b0;
        lsb_shift_d   = 1'b0;
        layer_start_d = '0;
        cache_shift_d = '0;
        out_valid_d   = 1'b0;
        error_d       = 1'b0;
        wd_clr        = 1'b0;
        wd_en         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sample_d    = in_data;
                    state_d     = SHIFT;
                    lsb_shift_d = 1'b1;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            SHIFT: begin
                idx_d         = '0;
                state_d       = START;
                layer_start_d = ONE_L;
            end
            START: begin
                wd_clr  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                wd_en = 1'b1;
                if (cur_done) begin
                    if (idx_q == LAST) begin
                        out_data_d  = layer_out;
                        out_valid_d = 1'b1;
                        state_d     = OUTPUT;
                    end else begin
                        cache_shift_d = ONE_C << idx_q;
                        state_d       = CACHE;
                    end
                end else if (wd_tc) begin
                    err_layer_d = idx_q;
                    error_d     = 1'b1;
                    state_d     = ERROR;
                end
            end
            CACHE: begin
                idx_d         = idx_q + 3'd1;
                layer_start_d = ONE_L << (idx_q + 3'd1);
                state_d       = START;
            end
            OUTPUT: begin
                if (out_ready) begin
                    in_ready_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            ERROR: begin
                if (err_clear) begin
                    in_ready_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    error_d = 1'b1;
                end
            end
            default: begin
                in_ready_d = 1'b1;
                state_d    = IDLE;
            end
        endcase
        busy_d = !(state_d == IDLE || state_d == ERROR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            sample_q      <= '0;
            out_data_q    <= '0;
            err_layer_q   <= '0;
            in_ready_q    <= 1'b1;
            lsb_shift_q   <= 1'b0;
            layer_start_q <= '0;
            cache_shift_q <= '0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            sample_q      <= sample_d;
            out_data_q    <= out_data_d;
            err_layer_q   <= err_layer_d;
            in_ready_q    <= in_ready_d;
            lsb_shift_q   <= lsb_shift_d;
            layer_start_q <= layer_start_d;
            cache_shift_q <= cache_shift_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            error_q       <= error_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign lsb_shift   = lsb_shift_q;
    assign layer_start = layer_start_q;
    assign cache_shift = cache_shift_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign error       = error_q;
    assign err_layer   = err_layer_q;

`ifdef CONV_SEQ_PERF_EN
    logic [15:0] perf_cnt_q, perf_cnt_d, perf_cycles_q, perf_cycles_d;

    // The counter reads 1 in the first cycle after the accept edge, so the value
    // latched on OUTPUT entry counts up to and including the first out_valid cycle.
    always_comb begin
        perf_cnt_d    = perf_cnt_q;
        perf_cycles_d = perf_cycles_q;
        if (state_q == IDLE && state_d == SHIFT) begin
            perf_cnt_d = 16'd1;
        end else if (busy_q && perf_cnt_q != 16'hFFFF) begin
            perf_cnt_d = perf_cnt_q + 16'd1;
        end
        if (state_q == WAIT && state_d == OUTPUT) begin
            perf_cycles_d = (perf_cnt_q == 16'hFFFF) ? 16'hFFFF : perf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt_q    <= '0;
            perf_cycles_q <= '0;
        end else begin
            perf_cnt_q    <= perf_cnt_d;
            perf_cycles_q <= perf_cycles_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
`endif

endmodule
